readout_mac: RTL and testbench

READOUT_MAC -- requirements
Module: readout_mac

---
 rtl/esn_pkg.sv | 51 +++++
 rtl/readout_weight_rf.sv | 51 +++++
 rtl/readout_mac.sv | 228 ++++++++++++++++++++++
 tb/tb_readout_mac.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/esn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : esn_pkg
//  Description : Shared definitions for the reservoir readout MAC: accumulator
//                width helper, FSM state encoding and the signed narrowing
//                (saturate / truncate) function.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package esn_pkg;

  // Widest intermediate used by the narrowing function.
  localparam int NARROW_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Enough headroom for the sum of `neurons` full-scale products.
  function automatic int acc_width(input int data_w, input int weight_w,
                                   input int neurons);
    return data_w + weight_w + $clog2(neurons);
  endfunction

  // Narrow a signed value to out_w bits. The result is returned sign-extended
  // to NARROW_W; the caller keeps the low out_w bits.
  function automatic logic signed [NARROW_W-1:0] narrow(
    input logic signed [NARROW_W-1:0] value,
    input int                         out_w,
    input bit                         saturate
  );
    logic signed [NARROW_W-1:0] max_v;
    logic signed [NARROW_W-1:0] min_v;
    logic signed [NARROW_W-1:0] result;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (saturate) begin
      if (value > max_v)      result = max_v;
      else if (value < min_v) result = min_v;
      else                    result = value;
    end else begin
      // Keep the low out_w bits, then re-extend their sign.
      result = (value <<< (NARROW_W - out_w)) >>> (NARROW_W - out_w);
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/readout_weight_rf.sv
`default_nettype none
// ============================================================================
//  Module      : readout_weight_rf
//  Description : Readout weight register file. Synchronous write, purely
//                combinational read, asynchronous clear of every entry.
//                Write addresses at or beyond DEPTH match no entry and are
//                silently dropped.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low clear
//                we     - write enable
//                waddr  - write index
//                wdata  - write value
//                raddr  - read index
//                rdata  - read value (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module readout_weight_rf #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == ADDR_W'(i)) mem[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) rdata = mem[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/readout_mac.sv
`default_nettype none
// ============================================================================
//  Module      : readout_mac
//  Description : Echo-state-network linear readout. Accepts one reservoir
//                state vector, computes OUT_CHANNELS dot products against a
//                programmable weight matrix with one multiply-accumulate per
//                cycle, and presents all channels together with a
//                valid/ready handshake.
//  Config      : READOUT_SATURATE_EN - defined: out-of-range results clamp;
//                undefined: results wrap to the low OUT_WIDTH bits.
//  Ports       : iClk    - clock
//                iRst_n  - asynchronous active-low reset
//                iValid / iData / oReady   - state vector input handshake
//                iWeWr / iWeAddr / iWeData - weight write port (IDLE only)
//                oValue / oValid / iReady  - result output handshake
//                oBusy   - high whenever not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module readout_mac
  import esn_pkg::*;
#(
  parameter int RESERVOIR_SIZE = 4,
  parameter int DATA_WIDTH     = 3,
  parameter int WEIGHT_SIZE    = 2,
  parameter int OUT_CHANNELS   = 2,
  parameter int OUT_WIDTH      = 8,
  localparam int ADDR_W = (OUT_CHANNELS * RESERVOIR_SIZE > 1) ?
                          $clog2(OUT_CHANNELS * RESERVOIR_SIZE) : 1
) (
  input  logic                                 iClk,
  input  logic                                 iRst_n,
  input  logic                                 iValid,
  input  logic [RESERVOIR_SIZE*DATA_WIDTH-1:0] iData,
  output logic                                 oReady,
  input  logic                                 iWeWr,
  input  logic [ADDR_W-1:0]                    iWeAddr,
  input  logic [WEIGHT_SIZE-1:0]               iWeData,
  output logic [OUT_CHANNELS*OUT_WIDTH-1:0]    oValue,
  output logic                                 oValid,
  input  logic                                 iReady,
  output logic                                 oBusy
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, WEIGHT_SIZE, RESERVOIR_SIZE);
  localparam int N_W    = OUT_CHANNELS * RESERVOIR_SIZE;
  localparam int K_W    = (RESERVOIR_SIZE > 1) ? $clog2(RESERVOIR_SIZE) : 1;
  localparam int CH_W   = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;

`ifdef READOUT_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases two edges after iRst_n rises.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // --------------------------------------------------------------------------
  // Datapath storage
  // --------------------------------------------------------------------------
  logic [RESERVOIR_SIZE*DATA_WIDTH-1:0] data_q;
  logic [K_W-1:0]                       k_cnt;
  logic [CH_W-1:0]                      ch_cnt;
  logic                                 issuing;
  logic signed [ACC_W-1:0]              prod_q;
  logic                                 prod_vld;
  logic                                 prod_wrap;
  logic                                 prod_final;
  logic [CH_W-1:0]                      prod_ch;
  logic signed [ACC_W-1:0]              acc;
  logic signed [OUT_WIDTH-1:0]          out_q [OUT_CHANNELS];

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  state_t state;
  state_t state_next;
  logic   accept;
  logic   we_en;

  always_ff @(posedge iClk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    oReady     = 1'b0;
    oValid     = 1'b0;
    oBusy      = 1'b1;
    accept     = 1'b0;
    we_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        oReady = 1'b1;
        oBusy  = 1'b0;
        we_en  = iWeWr;
        if (iValid) begin
          accept     = 1'b1;
          state_next = ST_MAC;
        end
      end
      ST_MAC: begin
        // Leave once the last product has been folded into its channel.
        if (prod_vld && prod_final) state_next = ST_OUT;
      end
      ST_OUT: begin
        oValid = 1'b1;
        if (iReady) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Weight storage
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0]      rf_raddr;
  logic [WEIGHT_SIZE-1:0] rf_rdata;

  assign rf_raddr = ADDR_W'(ch_cnt) * ADDR_W'(RESERVOIR_SIZE) + ADDR_W'(k_cnt);

  readout_weight_rf #(
    .DEPTH  (N_W),
    .ADDR_W (ADDR_W),
    .WIDTH  (WEIGHT_SIZE)
  ) u_weight_rf (
    .clk   (iClk),
    .rst_n (rst_n),
    .we    (we_en),
    .waddr (iWeAddr),
    .wdata (iWeData),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  // --------------------------------------------------------------------------
  // Multiply: the product is registered before accumulation, which is what
  // gives the one extra cycle between the last issue and the result.
  // --------------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0]  neuron;
  logic signed [WEIGHT_SIZE-1:0] weight;
  logic signed [ACC_W-1:0]       product;
  logic signed [ACC_W-1:0]       acc_sum;
  logic signed [OUT_WIDTH-1:0]   narrowed;
  logic                          k_last;
  logic                          ch_last;

  always_comb begin
    neuron = '0;
    for (int i = 0; i < RESERVOIR_SIZE; i++) begin
      if (k_cnt == K_W'(i)) neuron = data_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign weight   = rf_rdata;
  assign product  = ACC_W'(neuron) * ACC_W'(weight);
  assign acc_sum  = acc + prod_q;
  assign narrowed = OUT_WIDTH'(narrow(NARROW_W'(acc_sum), OUT_WIDTH, SATURATE));
  assign k_last   = (k_cnt == K_W'(RESERVOIR_SIZE - 1));
  assign ch_last  = (ch_cnt == CH_W'(OUT_CHANNELS - 1));

  always_ff @(posedge iClk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      k_cnt      <= '0;
      ch_cnt     <= '0;
      issuing    <= 1'b0;
      prod_q     <= '0;
      prod_vld   <= 1'b0;
      prod_wrap  <= 1'b0;
      prod_final <= 1'b0;
      prod_ch    <= '0;
      acc        <= '0;
      for (int c = 0; c < OUT_CHANNELS; c++) out_q[c] <= '0;
    end else if (accept) begin
      data_q   <= iData;
      acc      <= '0;
      k_cnt    <= '0;
      ch_cnt   <= '0;
      issuing  <= 1'b1;
      prod_vld <= 1'b0;
    end else if (state == ST_MAC) begin
      // Issue stage: one (ch, k) pair per cycle, k innermost.
      prod_vld <= issuing;
      if (issuing) begin
        prod_q     <= product;
        prod_wrap  <= k_last;
        prod_final <= k_last && ch_last;
        prod_ch    <= ch_cnt;
        if (k_last) begin
          k_cnt <= '0;
          if (ch_last) issuing <= 1'b0;
          else         ch_cnt  <= ch_cnt + CH_W'(1);
        end else begin
          k_cnt <= k_cnt + K_W'(1);
        end
      end
      // Accumulate stage: a wrapping product closes its channel.
      if (prod_vld) begin
        if (prod_wrap) begin
          acc <= '0;
          for (int c = 0; c < OUT_CHANNELS; c++) begin
            if (prod_ch == CH_W'(c)) out_q[c] <= narrowed;
          end
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  for (genvar c = 0; c < OUT_CHANNELS; c++) begin : g_pack
    assign oValue[c*OUT_WIDTH +: OUT_WIDTH] = out_q[c];
  end

endmodule
`default_nettype wire

// File: tb/tb_readout_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_readout_mac
//  Description : Directed self-checking bench for readout_mac. A default
//                instance covers the main function; a second instance with
//                OUT_WIDTH=4 covers the narrowing behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_readout_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        valid, ready_o, we_wr, ovalid, iready, busy;
  logic [11:0] data;
  logic [2:0]  we_addr;
  logic [1:0]  we_data;
  logic [15:0] value;

  logic        valid4, ready4, wr4, ovalid4, iready4, busy4;
  logic [11:0] data4;
  logic [2:0]  addr4;
  logic [1:0]  wdata4;
  logic [7:0]  value4;

  int checks   = 0;
  int failures = 0;

  bit count_en  = 1'b0;
  int acc_count = 0;

  readout_mac dut (
    .iClk(clk), .iRst_n(rst_n), .iValid(valid), .iData(data), .oReady(ready_o),
    .iWeWr(we_wr), .iWeAddr(we_addr), .iWeData(we_data),
    .oValue(value), .oValid(ovalid), .iReady(iready), .oBusy(busy)
  );

  readout_mac #(.OUT_WIDTH(4)) dut4 (
    .iClk(clk), .iRst_n(rst_n), .iValid(valid4), .iData(data4), .oReady(ready4),
    .iWeWr(wr4), .iWeAddr(addr4), .iWeData(wdata4),
    .oValue(value4), .oValid(ovalid4), .iReady(iready4), .oBusy(busy4)
  );

  always @(posedge clk) begin
    if (count_en && valid && ready_o) acc_count++;
  end

  localparam logic [11:0] VEC_A = 12'b011_110_010_001; // 3,-2,2,1
  localparam logic [11:0] VEC_3 = 12'b011_011_011_011; // all 3
  localparam logic [11:0] VEC_M = 12'b100_100_100_100; // all -4

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic [2:0] a, input logic [1:0] d);
    we_wr = 1'b1; we_addr = a; we_data = d;
    tick();
    we_wr = 1'b0;
  endtask

  task automatic load_pm_weights();
    for (int a = 0; a < 4; a++) write_w(3'(a), 2'b01);
    for (int a = 4; a < 8; a++) write_w(3'(a), 2'b11);
  endtask

  // Drives one transaction and returns the result and its latency in cycles
  // after the accepting edge (40 means it never completed).
  task automatic do_txn(input logic [11:0] d, input bit ack, input bit busy_wr,
                        input logic [2:0] wa, input logic [1:0] wd,
                        output logic [15:0] val, output int lat);
    valid = 1'b1; data = d;
    tick();
    valid = 1'b0;
    we_wr = busy_wr; we_addr = wa; we_data = wd;
    lat = 0;
    while (ovalid !== 1'b1 && lat < 40) begin tick(); lat++; end
    val = value;
    if (ack) begin iready = 1'b1; tick(); iready = 1'b0; end
    we_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (ovalid !== 1'b0) begin failures++; $display("FAIL rst_ovalid: got %b want 0", ovalid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (value !== 16'h0000) begin failures++; $display("FAIL rst_value: got %h want 0000", value); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    rst_n = 1'b1; valid = 1'b1; data = 12'h000;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_early_accept: busy %b want 0", busy); end
    valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    logic [15:0] v; int lat;
    load_pm_weights();
    do_txn(VEC_A, 1'b1, 1'b0, 3'd0, 2'd0, v, lat);
    checks++; if (v !== 16'hFC04) begin failures++; $display("FAIL basic_value: got %h want FC04", v); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL basic_latency: got %0d want 9", lat); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL basic_ready_after: got %b want 1", ready_o); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_saturate();
    int lat;
    logic [7:0] exp4;
`ifdef READOUT_SATURATE_EN
    exp4 = 8'h77;
`else
    exp4 = 8'hCC;
`endif
    for (int a = 0; a < 8; a++) begin
      wr4 = 1'b1; addr4 = 3'(a); wdata4 = 2'b01;
      tick();
    end
    wr4 = 1'b0;
    valid4 = 1'b1; data4 = VEC_3;
    tick();
    valid4 = 1'b0;
    lat = 0;
    while (ovalid4 !== 1'b1 && lat < 40) begin tick(); lat++; end
    checks++; if (value4 !== exp4) begin failures++; $display("FAIL narrow_value: got %h want %h", value4, exp4); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL narrow_latency: got %0d want 9", lat); end
    iready4 = 1'b1; tick(); iready4 = 1'b0;
  endtask

  task automatic test_hold();
    logic [15:0] v; int lat;
    do_txn(VEC_A, 1'b0, 1'b0, 3'd0, 2'd0, v, lat);
    checks++; if (v !== 16'hFC04) begin failures++; $display("FAIL hold_first: got %h want FC04", v); end
    valid = 1'b1; data = VEC_3;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (ovalid !== 1'b1) begin failures++; $display("FAIL hold_ovalid[%0d]: got %b want 1", i, ovalid); end
      checks++; if (value !== 16'hFC04) begin failures++; $display("FAIL hold_value[%0d]: got %h want FC04", i, value); end
      checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL hold_ready[%0d]: got %b want 0", i, ready_o); end
    end
    iready = 1'b1;
    tick();
    iready = 1'b0;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL hold_release_ready: got %b want 1", ready_o); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_release_busy: got %b want 0", busy); end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [15:0] v; int lat;
    valid = 1'b1; data = VEC_A;
    tick();
    valid = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #2;
    checks++; if (ovalid !== 1'b0) begin failures++; $display("FAIL mid_ovalid: got %b want 0", ovalid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (value !== 16'h0000) begin failures++; $display("FAIL mid_value: got %h want 0000", value); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) tick();
    do_txn(VEC_A, 1'b1, 1'b0, 3'd0, 2'd0, v, lat);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL mid_zero_weights: got %h want 0000", v); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL mid_latency: got %0d want 9", lat); end
  endtask

  task automatic test_busy_write();
    logic [15:0] v; int lat;
    write_w(3'd0, 2'b01);
    do_txn(VEC_A, 1'b1, 1'b1, 3'd1, 2'b01, v, lat);
    checks++; if (v !== 16'h0001) begin failures++; $display("FAIL busy_write_dropped: got %h want 0001", v); end
    write_w(3'd1, 2'b01);
    do_txn(VEC_A, 1'b1, 1'b0, 3'd0, 2'd0, v, lat);
    checks++; if (v !== 16'h0003) begin failures++; $display("FAIL idle_write_applied: got %h want 0003", v); end
    we_wr = 1'b1; we_addr = 3'd3; we_data = 2'b01;
    do_txn(VEC_A, 1'b1, 1'b0, 3'd0, 2'd0, v, lat);
    checks++; if (v !== 16'h0006) begin failures++; $display("FAIL same_cycle_write: got %h want 0006", v); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] vecs [3];
    logic [15:0] exps [3];
    int n, lat, stray;
    vecs[0] = VEC_3;   exps[0] = 16'hF40C;
    vecs[1] = 12'h000; exps[1] = 16'h0000;
    vecs[2] = VEC_M;   exps[2] = 16'h10F0;
    load_pm_weights();
    acc_count = 0;
    count_en  = 1'b1;
    valid = 1'b1; iready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      data = vecs[t];
      n = 0;
      while (ready_o !== 1'b1 && n < 40) begin tick(); n++; end
      tick();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept[%0d]: busy %b want 1", t, busy); end
      lat = 0; stray = 0;
      while (ovalid !== 1'b1 && lat < 40) begin
        if (ready_o !== 1'b0) stray++;
        tick(); lat++;
      end
      checks++; if (value !== exps[t]) begin failures++; $display("FAIL b2b_value[%0d]: got %h want %h", t, value, exps[t]); end
      checks++; if (lat !== 9) begin failures++; $display("FAIL b2b_latency[%0d]: got %0d want 9", t, lat); end
      checks++; if (stray !== 0) begin failures++; $display("FAIL b2b_ready_in_mac[%0d]: got %0d cycles want 0", t, stray); end
      tick();
      checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL b2b_idle[%0d]: ready %b want 1", t, ready_o); end
    end
    valid = 1'b0; iready = 1'b0;
    tick();
    count_en = 1'b0;
    checks++; if (acc_count !== 3) begin failures++; $display("FAIL b2b_accept_count: got %0d want 3", acc_count); end
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; data = '0; we_wr = 1'b0; we_addr = '0; we_data = '0; iready = 1'b0;
    valid4 = 1'b0; data4 = '0; wr4 = 1'b0; addr4 = '0; wdata4 = '0; iready4 = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_hold();
    test_reset_mid();
    test_busy_write();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
